// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI responder.
// No logic; imported by the interface and the top.
package spi_pkg;
    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the parallel tx/rx word ports of the responder.
// slave is the responder's view; master is the driving side (pins out, words in).
interface spi_slave_if #(parameter int DATA_W = spi_pkg::SPI_DATA_W);
    import spi_pkg::*;

    logic              SCLK;
    logic              CS;
    logic              MOSI;
    logic              MISO;
    logic              MISO_OE;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  SCLK, CS, MOSI, tx_data, tx_valid,
        output MISO, MISO_OE, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output SCLK, CS, MOSI, tx_data, tx_valid,
        input  MISO, MISO_OE, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin; latency SYNC_STAGES cycles.
// No backpressure; the reset value is chosen per pin by the instantiating block.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, pin-to-output latency SYNC_STAGES+1 cycles.
// tx side holds one word (tx_ready = empty); an empty holder at a word boundary sends zeros and pulses tx_underrun.
module spi_slave import spi_pkg::*; #(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic r_sclk_d, r_cs_d;
    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    spi_state_t r_state, w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-2:0] r_shift_in;
    logic [DATA_W-1:0] r_shift_out;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_underrun;
    logic              r_miso;
    logic              r_oe;
    logic              w_reload;
    logic              w_tx_wr;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(sys_clk), .rst_n(sys_rst_n), .i_d(bus.SCLK), .o_q(w_sclk_s));
    // CS resets to 0 so a CS already low at reset release never looks like a fresh fall.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(sys_clk), .rst_n(sys_rst_n), .i_d(bus.CS), .o_q(w_cs_s));
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(sys_clk), .rst_n(sys_rst_n), .i_d(bus.MOSI), .o_q(w_mosi_s));

    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
            r_state  <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_reload    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_fall && (r_cnt == '0)) begin
                    w_reload = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_tx_wr = bus.tx_valid && !r_hold_full;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt       <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            if (w_tx_wr) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end

            // A write can only land while the holder is empty, so a reload never races it.
            if (w_reload) begin
                if (r_hold_full) begin
                    r_shift_out <= r_hold;
                    r_miso      <= r_hold[DATA_W-1];
                    r_hold_full <= 1'b0;
                end else begin
                    r_shift_out <= '0;
                    r_miso      <= 1'b0;
                    r_underrun  <= 1'b1;
                end
            end

            if (r_state == ST_IDLE) begin
                if (w_cs_fall) begin
                    r_cnt <= '0;
                    r_oe  <= 1'b1;
                end
            end else if (w_cs_rise) begin
                r_cnt  <= '0;
                r_oe   <= 1'b0;
                r_miso <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_shift_in <= {r_shift_in[DATA_W-3:0], w_mosi_s};
                    if (r_cnt == CNT_W'(DATA_W-1)) begin
                        r_cnt      <= '0;
                        r_rx_data  <= {r_shift_in, w_mosi_s};
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                if (w_sclk_fall && (r_cnt != '0)) begin
                    r_shift_out <= r_shift_out << 1;
                    r_miso      <= r_shift_out[DATA_W-2];
                end
            end
        end
    end

    assign bus.MISO        = r_miso;
    assign bus.MISO_OE     = r_oe;
    assign bus.tx_ready    = ~r_hold_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_underrun;
    assign bus.busy        = (r_state == ST_ACTIVE);
endmodule
